// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor computing D = A - B (mod 2^WIDTH) with a
//   final borrow. A single full-subtractor cell is reused LSB-first, one bit
//   per clock, so a result takes WIDTH cycles after the request is accepted.
//
//   Handshake: start is sampled only in IDLE. The accepting edge captures A
//   and B. After that edge A and B may change freely. busy is high for the
//   WIDTH cycles of SHIFT. done is a one-cycle pulse in DONE. D/Bout are
//   registered, hold the previous result until the next completion, and are
//   never updated with partial values. start seen in SHIFT or DONE is dropped.
//
//   Optional feature (macro SERIAL_SUB_OVF_EN): adds output V, the signed
//   two's-complement overflow flag. It is computed from the operand MSBs
//   captured at start and is updated together with D.
//
// Ports
//   clk        in   1      rising-edge system clock
//   rst        in   1      synchronous, active-high reset
//   start      in   1      operation request (IDLE only)
//   A          in   WIDTH  minuend
//   B          in   WIDTH  subtrahend
//   busy       out  1      high while in SHIFT
//   done       out  1      one-cycle completion pulse
//   D          out  WIDTH  registered difference
//   Bout       out  1      registered final borrow (A < B unsigned)
//   V          out  1      signed overflow (only with SERIAL_SUB_OVF_EN)
//   dbg_state  out  2      current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             V,
`endif
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 result bits produced so far; the newest bit is
    // joined on top combinationally, so the full result is r_next.
    logic [WIDTH-2:0] r_sr;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] r_next;
    logic             last_bit;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Full-subtractor cell on the current LSBs.
    always_comb begin
        a0       = a_sr[0];
        b0       = b_sr[0];
        d_bit    = a0 ^ b0 ^ br;
        br_next  = (~a0 & b0) | (~(a0 ^ b0) & br);
        r_next   = {d_bit, r_sr};
        last_bit = (cnt == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_SHIFT;
            S_SHIFT: if (last_bit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign busy      = (state == S_SHIFT);
    assign done      = (state == S_DONE);
    assign dbg_state = state;

    // Datapath: operand capture, serial shift, result commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            D     <= '0;
            Bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            V     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= A;
                        b_sr  <= B;
                        r_sr  <= '0;
                        br    <= 1'b0;
                        cnt   <= '0;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb <= A[WIDTH-1];
                        b_msb <= B[WIDTH-1];
`endif
                    end
                end
                S_SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= r_next[WIDTH-1:1];
                    br   <= br_next;
                    cnt  <= cnt + CW'(1);
                    // Commit only the complete result so D never shows
                    // a partially shifted value.
                    if (last_bit) begin
                        D    <= r_next;
                        Bout <= br_next;
`ifdef SERIAL_SUB_OVF_EN
                        V    <= (a_msb != b_msb) && (r_next[WIDTH-1] != a_msb);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor at WIDTH=4. Expected results
//   are pushed when an operation is launched and popped by a monitor when
//   done pulses. Between completions the monitor checks that D/Bout hold.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int W = 4;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         done;
    logic [W-1:0] D;
    logic         Bout;
    logic [1:0]   dbg_state;
`ifdef SERIAL_SUB_OVF_EN
    logic         V;
`endif

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .D         (D),
        .Bout      (Bout),
`ifdef SERIAL_SUB_OVF_EN
        .V         (V),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [W+1:0] exp_q[$];   // {v, bout, d}
    logic [W-1:0] held_d = '0;
    logic         held_b = 1'b0;
    logic         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] d, input logic bout);
        logic v;
        v = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
        exp_q.push_back({v, bout, d});
    endtask

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [W+1:0] e;
        if (rst) begin
            held_d = '0;
            held_b = 1'b0;
        end else if (mon_en) begin
            if (busy && done) check("busy_done_excl", 1, 0);
            if (done) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("result_d", D, e[W-1:0]);
                    check("result_bout", Bout, e[W]);
`ifdef SERIAL_SUB_OVF_EN
                    check("result_v", V, e[W+1]);
`endif
                    held_d = e[W-1:0];
                    held_b = e[W];
                end
            end else begin
                check("hold_d", D, held_d);
                check("hold_bout", Bout, held_b);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Launch one operation from IDLE and check busy length and done latency.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] d, input logic bout);
        int busy_n;
        int done_at;
        busy_n  = 0;
        done_at = -1;
        @(posedge clk); #1;
        A = a; B = b; start = 1'b1;
        push_exp(a, b, d, bout);
        @(posedge clk); #1;              // accepting edge
        start = 1'b0;
        A = W'($urandom_range(0, 15));   // operands may change after accept
        B = W'($urandom_range(0, 15));
        for (int i = 1; i <= W + 3; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (done && done_at < 0) done_at = i;
        end
        check("busy_cycles", busy_n, W);
        check("done_latency", done_at, W + 1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         bout;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int first;
        int second;
        int cyc;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0]  = '{4'd5,  4'd3,  4'd2,  1'b0};
        vecs[1]  = '{4'd3,  4'd5,  4'hE,  1'b1};
        vecs[2]  = '{4'd0,  4'd0,  4'd0,  1'b0};
        vecs[3]  = '{4'd0,  4'd1,  4'hF,  1'b1};
        vecs[4]  = '{4'd15, 4'd0,  4'hF,  1'b0};
        vecs[5]  = '{4'd15, 4'd15, 4'd0,  1'b0};
        vecs[6]  = '{4'd0,  4'd15, 4'd1,  1'b1};
        vecs[7]  = '{4'd8,  4'd1,  4'd7,  1'b0};
        vecs[8]  = '{4'd6,  4'd2,  4'd4,  1'b0};
        vecs[9]  = '{4'd9,  4'd4,  4'd5,  1'b0};
        vecs[10] = '{4'd4,  4'd9,  4'hB,  1'b1};
        vecs[11] = '{4'd7,  4'd8,  4'hF,  1'b1};

        // ---------------- reset ----------------
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_d", D, 0);
        check("reset_bout", Bout, 0);
        check("reset_state", dbg_state, ST_IDLE);

        // ---------------- table vectors ----------------
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bout);
        end

        // ---------------- random vectors ----------------
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            run_op(ra, rb, ra - rb, (ra < rb));
        end

        // ---------------- start held high: back-to-back ----------------
        @(posedge clk); #1;
        A = 4'd9; B = 4'd4; start = 1'b1;
        push_exp(4'd9, 4'd4, 4'd5, 1'b0);
        push_exp(4'd4, 4'd9, 4'hB, 1'b1);
        @(posedge clk); #1;              // first accept
        A = 4'd4; B = 4'd9;
        first = -1; second = -1; cyc = 0;
        for (int i = 0; i < 40 && second < 0; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (first < 0) first = cyc;
                else second = cyc;
            end
            if (first >= 0 && busy) start = 1'b0;   // second op accepted
        end
        start = 1'b0;
        check("held_start_two_dones", (first > 0) && (second > 0), 1);
        check("held_start_gap", second - first, W + 2);
        repeat (3) @(negedge clk);

        // ---------------- reset mid-operation ----------------
        @(posedge clk); #1;
        A = 4'd7; B = 4'd2; start = 1'b1;
        @(posedge clk); #1;              // accept
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;              // two bits into SHIFT
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_d", D, 0);
        check("abort_bout", Bout, 0);
        check("abort_state", dbg_state, ST_IDLE);
        repeat (W + 3) @(negedge clk);   // monitor flags any stray done
        run_op(4'd12, 4'd5, 4'd7, 1'b0);

        // ---------------- start ignored in SHIFT and DONE ----------------
        @(posedge clk); #1;
        A = 4'd10; B = 4'd3; start = 1'b1;
        push_exp(4'd10, 4'd3, 4'd7, 1'b0);
        @(posedge clk); #1;              // accept
        start = 1'b0; A = 4'd1; B = 4'd2;
        @(posedge clk); #1;
        start = 1'b1;                    // pulse during SHIFT
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ignore_done_seen", done, 1);
        start = 1'b1;                    // pulse during DONE
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("ignore_state_idle", dbg_state, ST_IDLE);
        repeat (W + 3) @(negedge clk);
        check("ignore_not_busy", busy, 0);

        // ---------------- end ----------------
        repeat (2) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: ends the run with a failure line if the sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
